// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helpers for serial_sub_param
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit_w);
    return (digit_w > 0) ? width / digit_w : 1;
  endfunction

  // A single-step configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// rtl/sub_digit.sv - combinational DIGIT_W-bit ripple subtractor (a - b - bin)
module sub_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
    assign d[i]       = a[i] ^ b[i] ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[DIGIT_W];

endmodule

// File: rtl/serial_sub_param.sv
// rtl/serial_sub_param.sv - multi-cycle subtractor, DIGIT_W bits per clock, LSB digit first
module serial_sub_param
  import serial_sub_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT_W);
  localparam int CW    = cnt_width(STEPS);

  if (DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_digit
    $error("serial_sub_param: DIGIT_W must divide WIDTH");
  end

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [WIDTH-1:0]           a_q;
  logic [WIDTH-1:0]           b_q;
  logic                       bq;
  logic [DIGIT_W-1:0]         d_dig;
  logic                       bout;
  logic [WIDTH+DIGIT_W-1:0]   diff_cat;
  logic                       accept;

  sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .bin  (bq),
    .d    (d_dig),
    .bout (bout)
  );

  // New digit enters from the MSB side so the LSB digit ends up at bit 0.
  assign diff_cat  = {d_dig, diff};

  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state == RUN);
  assign borrow    = bq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      bq    <= 1'b0;
      diff  <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            a_q   <= in1;
            b_q   <= in2;
            bq    <= borrow_in;
            cnt   <= '0;
            state <= RUN;
          end else if (state == HOLD && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff <= diff_cat[WIDTH+DIGIT_W-1:DIGIT_W];
          a_q  <= a_q >> DIGIT_W;
          b_q  <= b_q >> DIGIT_W;
          bq   <= bout;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_param.sv
// tb/tb_serial_sub_param.sv - scoreboard bench for serial_sub_param (WIDTH=8, DIGIT_W=2,1,4,8)
module tb_serial_sub_param;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      in1 = '0;
  logic [7:0]      in2 = '0;
  logic            bin = 1'b0;
  logic [3:0]      iv = '0;
  logic [3:0]      orr = '0;
  logic [3:0]      ir;
  logic [3:0]      ov;
  logic [3:0]      bo;
  logic [3:0]      bsy;
  logic [3:0][7:0] dif;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    serial_sub_param #(.WIDTH(8), .DIGIT_W(DW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in1       (in1),
      .in2       (in2),
      .borrow_in (bin),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .diff      (dif[g]),
      .borrow    (bo[g]),
      .busy      (bsy[g])
    );
  end

  function automatic int dw_of(input int idx);
    case (idx)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'd0, c};
    return {r[7:0], r[8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int idx, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input exp_t e);
    in1 = a; in2 = b; bin = c; iv[idx] = 1'b1;
    #1;
    chk("accept_in_ready", 32'(ir[idx]), 1);
    tick();
    iv[idx] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_result(input int idx);
    int   lat;
    exp_t e;
    lat = 0;
    while (!ov[idx] && lat < 64) begin
      chk("run_in_ready", 32'(ir[idx]), 0);
      chk("run_busy", 32'(bsy[idx]), 1);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(8 / dw_of(idx)));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("diff", 32'(dif[idx]), 32'(e.d));
      chk("borrow", 32'(bo[idx]), 32'(e.b));
    end
  endtask

  task automatic consume(input int idx);
    orr[idx] = 1'b1;
    tick();
    orr[idx] = 1'b0;
    chk("consumed_out_valid", 32'(ov[idx]), 0);
    chk("idle_in_ready", 32'(ir[idx]), 1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_in_ready", 32'(ir[0]), 1);
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_diff", 32'(dif[0]), 0);
    chk("rst_borrow", 32'(bo[0]), 0);
    rst_n = 1'b1;
    tick();

    // basic, wrap-around and borrow-in cases
    start(0, 8'h35, 8'h12, 1'b0, '{d: 8'h23, b: 1'b0}); wait_result(0); consume(0);
    start(0, 8'h00, 8'h01, 1'b0, '{d: 8'hFF, b: 1'b1}); wait_result(0); consume(0);
    start(0, 8'h10, 8'h0F, 1'b1, '{d: 8'h00, b: 1'b0}); wait_result(0); consume(0);

    // backpressure, with in_valid asserted during RUN (must be ignored)
    start(0, 8'h35, 8'h12, 1'b0, '{d: 8'h23, b: 1'b0});
    in1 = 8'hAA; in2 = 8'h55; iv[0] = 1'b1;
    wait_result(0);
    iv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 32'(ov[0]), 1);
      chk("bp_diff", 32'(dif[0]), 32'h23);
      chk("bp_in_ready", 32'(ir[0]), 0);
    end

    // back-to-back accept from HOLD
    in1 = 8'hFF; in2 = 8'h01; bin = 1'b0; iv[0] = 1'b1; orr[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(ir[0]), 1);
    tick();
    iv[0] = 1'b0; orr[0] = 1'b0;
    sb.push_back('{d: 8'hFE, b: 1'b0});
    chk("b2b_out_valid", 32'(ov[0]), 0);
    wait_result(0);
    consume(0);

    // reset mid-RUN discards the operation
    start(0, 8'h44, 8'h11, 1'b0, '{d: 8'h33, b: 1'b0});
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 0);
    chk("midrst_diff", 32'(dif[0]), 0);
    chk("midrst_in_ready", 32'(ir[0]), 1);
    chk("midrst_busy", 32'(bsy[0]), 0);
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start(0, 8'h80, 8'h7F, 1'b0, '{d: 8'h01, b: 1'b0}); wait_result(0); consume(0);

    // random sweep over every digit width
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [7:0] a, b;
        logic       c;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        c = 1'($urandom_range(0, 1));
        start(idx, a, b, c, model(a, b, c));
        wait_result(idx);
        consume(idx);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
